// File: rtl/muldiv_if.sv
// muldiv_if: operand, command and result bundle between a requester and the multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rso;
    logic [31:0] rto;
    logic        hiwrite;
    logic        lowrite;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divzero;
    modport master (output start, op, rso, rto, hiwrite, lowrite,
                    input busy, done, hi, lo, divzero);
    modport slave (input start, op, rso, rto, hiwrite, lowrite,
                   output busy, done, hi, lo, divzero);
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative 32x32 multiply / 32/32 restoring divide with hi/lo result registers.
// Fixed 33-cycle latency: 32 ITER steps on magnitudes, then one FIX cycle for signs.
module muldiv (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2;
    logic [1:0]  state_q, state_d, op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] p_q, p_d;
    logic        done_q, done_d, dz_q, dz_d;
    logic        is_div, a_neg, b_neg, dz;
    logic [31:0] mag_a, mag_b, quot, rem, fix_hi, fix_lo;
    logic [63:0] s, mul_nx, div_nx, prod;
    logic [32:0] ms, rs, df;
    always_comb begin
        is_div = op_q[1];
        a_neg  = op_q[0] & a_q[31];
        b_neg  = op_q[0] & b_q[31];
        mag_a  = a_neg ? -a_q : a_q;
        mag_b  = b_neg ? -b_q : b_q;
        // first step seeds the working register with multiplier or dividend
        s      = (cnt_q == 5'd0) ? {32'b0, is_div ? mag_a : mag_b} : p_q;
        ms     = {1'b0, s[63:32]} + {1'b0, mag_a};
        mul_nx = s[0] ? {ms, s[31:1]} : {1'b0, s[63:1]};
        rs     = {s[63:32], s[31]};
        df     = rs - {1'b0, mag_b};
        div_nx = df[32] ? {rs[31:0], s[30:0], 1'b0} : {df[31:0], s[30:0], 1'b1};
        prod   = (a_neg ^ b_neg) ? -p_q : p_q;
        quot   = (a_neg ^ b_neg) ? -p_q[31:0] : p_q[31:0];
        rem    = a_neg ? -p_q[63:32] : p_q[63:32];
        dz     = is_div & (b_q == 32'd0);
        fix_hi = !is_div ? prod[63:32] : dz ? a_q : rem;
        fix_lo = !is_div ? prod[31:0] : dz ? 32'hFFFF_FFFF : quot;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = ITER;
                cnt_d   = 5'd0;
                op_d    = bus.op;
                a_d     = bus.rso;
                b_d     = bus.rto;
                dz_d    = 1'b0;
            end else begin
                hi_d = bus.hiwrite ? bus.rso : hi_q;
                lo_d = bus.lowrite ? bus.rso : lo_q;
            end
        end else if (state_q == ITER) begin
            p_d     = is_div ? div_nx : mul_nx;
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'd31) ? FIX : ITER;
        end else if (state_q == FIX) begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            dz_d    = dz;
            done_d  = 1'b1;
            state_d = IDLE;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            p_q     <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.divzero = dz_q;
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: scoreboard bench for muldiv; expected results come from a behavioural arithmetic model.
module tb_muldiv;
    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    muldiv_if bus ();
    muldiv dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb2, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb2 = $signed(b);
        p = 64'd0;
        e.dz = 1'b0;
        if (op == 2'd0) p = {32'b0, a} * {32'b0, b};
        else if (op == 2'd1) p = sa * sb2;
        else if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (op == 2'd2) p = {a % b, a / b};
        else begin
            q = sa / sb2;
            r = sa % sb2;
            p = {r[31:0], q[31:0]};
        end
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.dz = op[1] && b == 32'd0;
        return e;
    endfunction
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op = op;
        bus.rso = a;
        bus.rto = b;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask
    task automatic wait_done(output int lat, output int bc);
        lat = -1;
        bc = bus.busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) bc++;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        exp_t got;
        bus.start = 1'b1;
        bus.op = 2'd0;
        bus.rso = 32'h1234_5678;
        bus.rto = 32'd3;
        bus.hiwrite = 1'b1;
        bus.lowrite = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (got !== 65'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: dz/hi/lo=%h busy=%b done=%b, need all zero", got, bus.busy, bus.done);
        end
        bus.start = 1'b0;
        bus.hiwrite = 1'b0;
        bus.lowrite = 1'b0;
        rst = 1'b1;
        tick();
    endtask
    task automatic test_mul();
        logic [1:0]  ops[5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
        logic [31:0] as[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF};
        logic [31:0] bs[5] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
        int lat, bc;
        exp_t e, got;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, bc);
            e = sb.pop_front();
            got = {bus.divzero, bus.hi, bus.lo};
            tests++;
            if (lat != 33 || bc != 33 || got !== e) begin
                fails++;
                $display("FAIL mul_%0d: lat=%0d busy=%0d res=%h, need lat=33 busy=33 res=%h", i, lat, bc, got, e);
            end
            tick();
            tests++;
            if (bus.done !== 1'b0) begin
                fails++;
                $display("FAIL done_pulse_%0d: done=%b, need 0", i, bus.done);
            end
        end
    endtask
    task automatic test_div();
        logic [1:0]  ops[6] = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};
        logic [31:0] as[6] = '{32'hFFFF_FFF9, 32'h0000_000A, 32'h0000_0007, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FF9C};
        logic [31:0] bs[6] = '{32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0010, 32'h0000_0003, 32'hFFFF_FFF9};
        int lat, bc;
        exp_t e, got;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, bc);
            e = sb.pop_front();
            got = {bus.divzero, bus.hi, bus.lo};
            tests++;
            if (lat != 33 || got !== e) begin
                fails++;
                $display("FAIL div_%0d: lat=%0d res=%h, need lat=33 res=%h", i, lat, got, e);
            end
        end
    endtask
    task automatic test_divzero();
        int lat, bc;
        exp_t e, got;
        issue(2'd2, 32'h0000_000A, 32'd0);
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (lat != 33 || got !== e) begin
            fails++;
            $display("FAIL divzero_u: lat=%0d res=%h, need lat=33 res=%h", lat, got, e);
        end
        bus.rso = 32'h0000_0042;
        bus.lowrite = 1'b1;
        tick();
        bus.lowrite = 1'b0;
        tests++;
        if (bus.divzero !== 1'b1 || bus.lo !== 32'h42) begin
            fails++;
            $display("FAIL divzero_hold: dz=%b lo=%h, need dz=1 lo=00000042", bus.divzero, bus.lo);
        end
        issue(2'd3, 32'hFFFF_FFFB, 32'd0);
        tests++;
        if (bus.divzero !== 1'b0) begin
            fails++;
            $display("FAIL divzero_clear: dz=%b, need 0 after start", bus.divzero);
        end
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL divzero_s: res=%h, need %h", got, e);
        end
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (lat != 33 || got !== e) begin
            fails++;
            $display("FAIL div_overflow: lat=%0d res=%h, need lat=33 res=%h", lat, got, e);
        end
    endtask
    task automatic test_busy_ignore();
        int lat, bc;
        exp_t e, got;
        issue(2'd0, 32'd2, 32'd3);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.op = 2'd3;
        bus.rso = 32'h0000_0055;
        bus.rto = 32'h0000_0009;
        bus.hiwrite = 1'b1;
        bus.lowrite = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hiwrite = 1'b0;
        bus.lowrite = 1'b0;
        tests++;
        if (bus.hi === 32'h55 || bus.lo === 32'h55) begin
            fails++;
            $display("FAIL busy_mt: hi=%h lo=%h, need neither to be 00000055", bus.hi, bus.lo);
        end
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (lat != 28 || got !== e) begin
            fails++;
            $display("FAIL busy_ignore: lat=%0d res=%h, need lat=28 res=%h", lat, got, e);
        end
    endtask
    task automatic test_mt_and_start_wins();
        int lat, bc;
        exp_t e, got;
        bus.rso = 32'hAAAA_0000;
        bus.hiwrite = 1'b1;
        bus.lowrite = 1'b1;
        tick();
        bus.rso = 32'h0000_5555;
        bus.hiwrite = 1'b0;
        tick();
        bus.lowrite = 1'b0;
        tests++;
        if (bus.hi !== 32'hAAAA_0000 || bus.lo !== 32'h0000_5555) begin
            fails++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h, need aaaa0000 00005555", bus.hi, bus.lo);
        end
        bus.hiwrite = 1'b1;
        bus.lowrite = 1'b1;
        issue(2'd0, 32'd5, 32'd7);
        bus.hiwrite = 1'b0;
        bus.lowrite = 1'b0;
        tests++;
        if (bus.hi !== 32'hAAAA_0000 || bus.lo !== 32'h0000_5555 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL start_wins: hi=%h lo=%h busy=%b, need aaaa0000 00005555 1", bus.hi, bus.lo, bus.busy);
        end
        repeat (16) tick();
        tests++;
        if (bus.hi !== 32'hAAAA_0000 || bus.lo !== 32'h0000_5555) begin
            fails++;
            $display("FAIL iter_hold: hi=%h lo=%h, need aaaa0000 00005555", bus.hi, bus.lo);
        end
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL start_wins_res: res=%h, need %h", got, e);
        end
    endtask
    task automatic test_back_to_back();
        int lat, bc;
        exp_t e, got;
        issue(2'd2, 32'd100, 32'd7);
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL b2b_first: res=%h, need %h", got, e);
        end
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b, need 1", bus.busy);
        end
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (lat != 33 || got !== e) begin
            fails++;
            $display("FAIL b2b_second: lat=%0d res=%h, need lat=33 res=%h", lat, got, e);
        end
    endtask
    task automatic test_reset_mid();
        int lat, bc;
        exp_t e, got;
        logic seen;
        issue(2'd3, 32'hFFFF_FF00, 32'd7);
        void'(sb.pop_back());
        repeat (9) tick();
        rst = 1'b0;
        tick();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (got !== 65'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: res=%h busy=%b done=%b, need all zero", got, bus.busy, bus.done);
        end
        rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | bus.done;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done: done seen=%b, need 0", seen);
        end
        issue(2'd0, 32'd4, 32'd4);
        wait_done(lat, bc);
        e = sb.pop_front();
        got = {bus.divzero, bus.hi, bus.lo};
        tests++;
        if (lat != 33 || got !== e) begin
            fails++;
            $display("FAIL reset_recover: lat=%0d res=%h, need lat=33 res=%h", lat, got, e);
        end
    endtask
    initial begin
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.rso = 32'd0;
        bus.rto = 32'd0;
        bus.hiwrite = 1'b0;
        bus.lowrite = 1'b0;
        #1;
        test_reset();
        test_mul();
        test_div();
        test_divzero();
        test_busy_ignore();
        test_mt_and_start_wins();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL: clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL: rst, input, 1, synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-003 SHALL: start, input, 1, request a new operation using op, rso, rto.
REQ-004 SHALL: op, input, 2, 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL: rso, input, 32, operand A (multiplicand/dividend), sourced from register-file rs read port.
REQ-006 SHALL: rto, input, 32, operand B (multiplier/divisor), sourced from register-file rt read port.
REQ-007 SHALL: hiwrite, input, 1, MTHI: load hi from rso.
REQ-008 SHALL: lowrite, input, 1, MTLO: load lo from rso.
REQ-009 SHALL: busy, output, 1, operation in progress; start ignored while high.
REQ-010 SHALL: done, output, 1, one-cycle pulse; hi/lo hold the new result.
REQ-011 SHALL: hi, output, 32, product[63:32] or remainder.
REQ-012 SHALL: lo, output, 32, product[31:0] or quotient.
REQ-013 SHALL: divzero, output, 1, last completed divide had rto = 0.

Function
REQ-014 SHALL: FSM states IDLE, ITER, FIX; reset state IDLE.
REQ-015 SHALL: in IDLE with start=1 at edge E, latch op, rso, rto, clear divzero, and go to ITER; busy=1 from E.
REQ-016 SHALL: ITER lasts exactly 32 cycles, driven by a 5-bit counter; one shift-add (multiply) or restoring subtract-shift (divide) step per cycle, on unsigned magnitudes.
REQ-017 SHALL: FIX lasts 1 cycle; it applies sign correction and writes hi/lo at edge E+33.
REQ-018 SHALL: at edge E+33, busy drops to 0, done becomes 1 for exactly one cycle, and the FSM returns to IDLE.
REQ-019 SHALL: fixed latency is 33 cycles for every op, including divide by zero.
REQ-020 SHALL: MULT and DIV use absolute values of the two's-complement operands; MULTU and DIVU use raw operands.
REQ-021 SHALL: the 64-bit product is negated when operand signs differ (MULT only).
REQ-022 SHALL: for DIV, the quotient is negated when signs differ, and the remainder takes the sign of the dividend.
REQ-023 SHALL: for divide by zero (DIVU or DIV), set hi = latched rso, lo = 0xFFFFFFFF, and divzero = 1.
REQ-024 SHALL: DIV 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0, divzero = 0.
REQ-025 SHALL: hi/lo are unchanged during ITER; they change only in FIX, on MTHI/MTLO, or on reset.
REQ-026 SHALL: start while busy=1 is ignored; latched operands are unaffected.
REQ-027 SHALL: hiwrite/lowrite while busy=1 are ignored.
REQ-028 SHALL: in IDLE, hiwrite/lowrite update hi/lo from rso at the next edge; both asserted loads both.
REQ-029 SHALL: start with hiwrite or lowrite in the same IDLE cycle: start wins and the writes are dropped.
REQ-030 SHALL: start in the cycle where done=1 is accepted (FSM already IDLE).
REQ-031 SHALL: divzero holds its value until the next accepted start or reset.

Reset
REQ-032 SHALL: rst=0 at any edge forces IDLE with busy=0, done=0, divzero=0, hi=0, lo=0, and counter=0.
REQ-033 SHALL: reset mid-operation abandons the operation with no done pulse and no hi/lo update.
REQ-034 SHALL: rst=0 overrides start, hiwrite and lowrite in the same cycle.

Verification
REQ-035 SHALL: MULTU rso=0xFFFFFFFF, rto=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after start edge; busy high 33 cycles.
REQ-036 SHALL: MULT rso=0xFFFFFFFD (-3), rto=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 SHALL: DIV rso=0xFFFFFFF9 (-7), rto=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0x0000000A/0x00000003 -> lo=3, hi=1.
REQ-038 SHALL: DIVU rso=0x0000000A, rto=0 -> hi=0x0000000A, lo=0xFFFFFFFF, divzero=1; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, divzero=0.
REQ-039 SHALL: start MULTU 2*3, re-pulse start with other operands and pulse hiwrite at cycle 5 -> both ignored; result hi=0, lo=6.
REQ-040 SHALL: rst=0 at cycle 10 of a DIV -> next edge all outputs 0, no done; new MULTU 4*4 after release -> lo=0x10 after 33 cycles.
